// File: rtl/fab_clk_enable_gen.sv
// Multi-channel clock-enable generator: holds all strobes off until the fabric oscillator
// has settled, then emits per-channel single-cycle enables at programmable divisions of clk.
module fab_clk_enable_gen #(
  parameter int CHANNELS       = 4,
  parameter int DIV_W          = 16,
  parameter int STARTUP_CYCLES = 1024,
  parameter int DEFAULT_DIV    = 50,
  parameter int CH_W           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [DIV_W-1:0]    cfg_div,
  input  logic                cfg_en,
  input  logic                sync,
  output logic [CHANNELS-1:0] clken,
  output logic                osc_ready,
  output logic                cfg_err
);

  localparam int               SU_W    = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
  localparam logic [SU_W-1:0]  SU_LAST = SU_W'(STARTUP_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] CNT_RST = DIV_W'(DEFAULT_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  typedef enum logic {
    ST_SETTLE,
    ST_RUN
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [SU_W-1:0] su_cnt;
  logic [SU_W-1:0] su_cnt_nxt;

  logic [CHANNELS-1:0] en;
  logic [CHANNELS-1:0] en_nxt;
  logic [DIV_W-1:0]    div_q    [CHANNELS];
  logic [DIV_W-1:0]    div_nxt  [CHANNELS];
  logic [DIV_W-1:0]    pend_q   [CHANNELS];
  logic [DIV_W-1:0]    pend_nxt [CHANNELS];
  logic [DIV_W-1:0]    cnt_q    [CHANNELS];
  logic [DIV_W-1:0]    cnt_nxt  [CHANNELS];

  logic             cfg_fire;
  logic             cfg_oor;
  logic             cfg_hit;
  logic             sync_go;
  logic [DIV_W-1:0] cfg_div_eff;

  // ---------------------------------------------------------------------------
  // Oscillator settling
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt  = state;
    su_cnt_nxt = su_cnt;
    case (state)
      ST_SETTLE: begin
        if (su_cnt == SU_LAST) begin
          state_nxt = ST_RUN;
        end else begin
          su_cnt_nxt = su_cnt + SU_W'(1);
        end
      end
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_SETTLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_SETTLE;
      su_cnt <= '0;
    end else begin
      state  <= state_nxt;
      su_cnt <= su_cnt_nxt;
    end
  end

  assign osc_ready = (state == ST_RUN);
  assign cfg_ready = osc_ready;

  // ---------------------------------------------------------------------------
  // Configuration decode
  // ---------------------------------------------------------------------------
  assign cfg_fire    = cfg_valid & cfg_ready;
  assign cfg_oor     = (int'(cfg_ch) >= CHANNELS);
  assign cfg_hit     = cfg_fire & ~cfg_oor;
  assign sync_go     = sync & osc_ready;
  assign cfg_div_eff = (cfg_div == '0) ? DIV_ONE : cfg_div;

  // ---------------------------------------------------------------------------
  // Per-channel divider next state
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      en_nxt[i]   = en[i];
      div_nxt[i]  = div_q[i];
      pend_nxt[i] = pend_q[i];
      cnt_nxt[i]  = cnt_q[i];

      if (cfg_hit && (int'(cfg_ch) == i)) begin
        pend_nxt[i] = cfg_div_eff;
        if (!cfg_en) begin
          en_nxt[i] = 1'b0;
        end else if (!en[i] || sync_go) begin
          // A fresh start (or a start coinciding with SYNC) restarts the period from the new divisor.
          en_nxt[i]  = 1'b1;
          div_nxt[i] = cfg_div_eff;
          cnt_nxt[i] = cfg_div_eff - DIV_ONE;
        end else if (cnt_q[i] == '0) begin
          div_nxt[i] = cfg_div_eff;
          cnt_nxt[i] = cfg_div_eff - DIV_ONE;
        end else begin
          cnt_nxt[i] = cnt_q[i] - DIV_ONE;
        end
      end else if (en[i] && osc_ready) begin
        if (sync_go || (cnt_q[i] == '0)) begin
          div_nxt[i] = pend_q[i];
          cnt_nxt[i] = pend_q[i] - DIV_ONE;
        end else begin
          cnt_nxt[i] = cnt_q[i] - DIV_ONE;
        end
      end
    end
  end

  // NOTE: the small per-channel arrays are reset explicitly because their reset contents are
  // the architectural power-up configuration, not don't-care storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en      <= '1;
      cfg_err <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        div_q[i]  <= DIV_RST;
        pend_q[i] <= DIV_RST;
        cnt_q[i]  <= CNT_RST;
      end
    end else begin
      en <= en_nxt;
      if (cfg_fire && cfg_oor) begin
        cfg_err <= 1'b1;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        div_q[i]  <= div_nxt[i];
        pend_q[i] <= pend_nxt[i];
        cnt_q[i]  <= cnt_nxt[i];
      end
    end
  end

  // Strobes decode registered state only; no input reaches clken combinationally.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      clken[i] = osc_ready & en[i] & (cnt_q[i] == '0);
    end
  end

endmodule

// File: tb/tb_fab_clk_enable_gen.sv
// Directed bench for fab_clk_enable_gen: settling, strobe phase, divisor changes,
// enable/disable, SYNC alignment, out-of-range channel and mid-run reset.
module tb_fab_clk_enable_gen;

  localparam int CHANNELS       = 4;
  localparam int DIV_W          = 16;
  localparam int STARTUP_CYCLES = 1024;
  localparam int DEFAULT_DIV    = 50;
  localparam int CH_W           = 3;  // wide enough to present channel 5

  logic                clk       = 1'b0;
  logic                rst       = 1'b1;
  logic                cfg_valid = 1'b0;
  logic                cfg_ready;
  logic [CH_W-1:0]     cfg_ch    = '0;
  logic [DIV_W-1:0]    cfg_div   = '0;
  logic                cfg_en    = 1'b0;
  logic                sync      = 1'b0;
  logic [CHANNELS-1:0] clken;
  logic                osc_ready;
  logic                cfg_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fab_clk_enable_gen #(
    .CHANNELS      (CHANNELS),
    .DIV_W         (DIV_W),
    .STARTUP_CYCLES(STARTUP_CYCLES),
    .DEFAULT_DIV   (DEFAULT_DIV),
    .CH_W          (CH_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_en   (cfg_en),
    .sync     (sync),
    .clken    (clken),
    .osc_ready(osc_ready),
    .cfg_err  (cfg_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted configuration; returns in the first cycle after the accept edge.
  task automatic do_cfg(input int ch, input int div, input logic en_val);
    cfg_valid = 1'b1;
    cfg_ch    = CH_W'(ch);
    cfg_div   = DIV_W'(div);
    cfg_en    = en_val;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (clken !== '0) begin
      errors++; $display("FAIL reset_clken got %h want 0", clken);
    end
    checks++;
    if (osc_ready !== 1'b0) begin
      errors++; $display("FAIL reset_osc_ready got %b want 0", osc_ready);
    end
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++; $display("FAIL reset_cfg_ready got %b want 0", cfg_ready);
    end
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++; $display("FAIL reset_cfg_err got %b want 0", cfg_err);
    end
    tick();
  endtask

  // Releases reset, verifies settling length, then the first two aligned default strobes.
  // Ends 100 cycles after T, where every counter holds DEFAULT_DIV-1.
  task automatic test_startup(input string tag);
    logic [CHANNELS-1:0] want;
    cfg_valid = 1'b1;  // offered during settling; must not be accepted
    cfg_ch    = '0;
    cfg_div   = DIV_W'(3);
    cfg_en    = 1'b0;
    rst       = 1'b0;
    for (int k = 1; k <= STARTUP_CYCLES; k++) begin
      tick();
      checks++;
      if (osc_ready !== (k == STARTUP_CYCLES)) begin
        errors++; $display("FAIL %s_osc_ready k=%0d got %b want %b", tag, k, osc_ready, k == STARTUP_CYCLES);
      end
      checks++;
      if (cfg_ready !== (k == STARTUP_CYCLES)) begin
        errors++; $display("FAIL %s_cfg_ready k=%0d got %b want %b", tag, k, cfg_ready, k == STARTUP_CYCLES);
      end
      checks++;
      if (clken !== '0) begin
        errors++; $display("FAIL %s_early_clken k=%0d got %h want 0", tag, k, clken);
      end
      if (k == STARTUP_CYCLES - 1) cfg_valid = 1'b0;
    end
    for (int m = 1; m <= 100; m++) begin
      tick();
      want = (m == DEFAULT_DIV - 1 || m == 2 * DEFAULT_DIV - 1) ? '1 : '0;
      checks++;
      if (clken !== want) begin
        errors++; $display("FAIL %s_default_strobe m=%0d got %h want %h", tag, m, clken, want);
      end
    end
  endtask

  // Entered with all counters at 49; channel 1 finishes its 50-cycle gap, then runs at 10.
  task automatic test_div_change();
    do_cfg(1, 10, 1'b1);
    for (int a = 0; a <= 80; a++) begin
      if (a > 0) tick();
      checks++;
      if (clken[1] !== (a >= 48 && (a - 48) % 10 == 0)) begin
        errors++; $display("FAIL div_change_ch1 a=%0d got %b want %b", a, clken[1], (a >= 48 && (a - 48) % 10 == 0));
      end
      checks++;
      if (clken[0] !== (a == 48)) begin
        errors++; $display("FAIL div_change_ch0 a=%0d got %b want %b", a, clken[0], a == 48);
      end
    end
  endtask

  task automatic test_disable_enable();
    do_cfg(2, 50, 1'b0);
    for (int a = 0; a < 60; a++) begin
      if (a > 0) tick();
      checks++;
      if (clken[2] !== 1'b0) begin
        errors++; $display("FAIL disable_ch2 a=%0d got %b want 0", a, clken[2]);
      end
    end
    do_cfg(2, 1, 1'b1);
    for (int a = 0; a < 20; a++) begin
      if (a > 0) tick();
      checks++;
      if (clken[2] !== 1'b1) begin
        errors++; $display("FAIL enable_div1_ch2 a=%0d got %b want 1", a, clken[2]);
      end
    end
  endtask

  task automatic test_sync();
    do_cfg(0, 7, 1'b0);
    do_cfg(3, 13, 1'b0);
    do_cfg(0, 7, 1'b1);
    tick(); tick(); tick();
    do_cfg(3, 13, 1'b1);
    // ch0 counter is 2 here, ch3 counter is 12: out of phase
    for (int b = 0; b <= 20; b++) begin
      if (b > 0) tick();
      checks++;
      if (clken[0] !== (b >= 2 && (b - 2) % 7 == 0)) begin
        errors++; $display("FAIL presync_ch0 b=%0d got %b want %b", b, clken[0], (b >= 2 && (b - 2) % 7 == 0));
      end
      checks++;
      if (clken[3] !== (b == 12)) begin
        errors++; $display("FAIL presync_ch3 b=%0d got %b want %b", b, clken[3], b == 12);
      end
    end
    sync = 1'b1;
    tick();
    sync = 1'b0;
    for (int s = 0; s <= 13; s++) begin
      if (s > 0) tick();
      checks++;
      if (clken !== {s == 12, 1'b1, s == 9, (s == 6 || s == 13)}) begin
        errors++; $display("FAIL sync_align s=%0d got %b want %b", s, clken, {s == 12, 1'b1, s == 9, (s == 6 || s == 13)});
      end
    end
  endtask

  // SYNC and a config to channel 0 on the same edge.
  task automatic test_sync_with_cfg();
    sync = 1'b1;
    do_cfg(0, 4, 1'b1);
    sync = 1'b0;
    for (int r = 0; r <= 12; r++) begin
      if (r > 0) tick();
      checks++;
      if (clken !== {r == 12, 1'b1, r == 9, (r == 3 || r == 7 || r == 11)}) begin
        errors++; $display("FAIL sync_cfg r=%0d got %b want %b", r, clken, {r == 12, 1'b1, r == 9, (r == 3 || r == 7 || r == 11)});
      end
    end
  endtask

  task automatic test_cfg_err();
    int ch1_strobes;
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++; $display("FAIL cfg_err_pre got %b want 0", cfg_err);
    end
    do_cfg(3, 13, 1'b0);
    do_cfg(5, 0, 1'b1);
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++; $display("FAIL cfg_err_ready got %b want 1", cfg_ready);
    end
    ch1_strobes = 0;
    for (int a = 0; a < 30; a++) begin
      if (a > 0) tick();
      if (clken[1]) ch1_strobes++;
      checks++;
      if (cfg_err !== 1'b1) begin
        errors++; $display("FAIL cfg_err_sticky a=%0d got %b want 1", a, cfg_err);
      end
      checks++;
      if (clken[3] !== 1'b0) begin
        errors++; $display("FAIL cfg_err_ch3 a=%0d got %b want 0", a, clken[3]);
      end
    end
    checks++;
    if (ch1_strobes !== 3) begin
      errors++; $display("FAIL cfg_err_ch1_rate got %0d want 3", ch1_strobes);
    end
    do_cfg(3, 0, 1'b1);
    for (int a = 0; a < 10; a++) begin
      if (a > 0) tick();
      checks++;
      if (clken[3] !== 1'b1) begin
        errors++; $display("FAIL div0_as_div1_ch3 a=%0d got %b want 1", a, clken[3]);
      end
    end
  endtask

  task automatic test_reset_mid();
    checks++;
    if (clken[2] !== 1'b1) begin
      errors++; $display("FAIL pre_reset_ch2 got %b want 1", clken[2]);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (clken !== '0) begin
      errors++; $display("FAIL midreset_clken got %h want 0", clken);
    end
    checks++;
    if (osc_ready !== 1'b0) begin
      errors++; $display("FAIL midreset_osc_ready got %b want 0", osc_ready);
    end
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++; $display("FAIL midreset_cfg_ready got %b want 0", cfg_ready);
    end
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++; $display("FAIL midreset_cfg_err got %b want 0", cfg_err);
    end
    tick();
    tick();
    test_startup("restart");
  endtask

  initial begin
    test_reset();
    test_startup("startup");
    test_div_change();
    test_disable_enable();
    test_sync();
    test_sync_with_cfg();
    test_cfg_err();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
